pcie_class_route_switch: RTL and testbench

- Parametrised successor to the two-class, two-port device layer of the adaptive PCIe switching design.
- Classifies each input word by its class field into one of NUM_CLASS class FIFOs.
- Arbitrates among the class FIFOs and routes each winning word by its destination field into one of NUM_DEST output FIFOs.
- Software pops the output FIFOs; pause/almost flags and a sticky Error are exported.

---
 rtl/pcie_switch_pkg.sv | 32 +++
 rtl/sync_fifo_flags.sv | 94 +++++++++
 rtl/pcie_class_route_switch.sv | 150 +++++++++++++++
 tb/tb_pcie_class_route_switch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_switch_pkg.sv
// rtl/pcie_switch_pkg.sv - shared constants and helpers for the class/route switch
// Purpose: default field layout, field-extract positions, arbitration mode
//          constants and small elaboration-time helpers.
// Ports:   none (package).
package pcie_switch_pkg;

  localparam int DEF_MAIN_SIZE  = 8;
  localparam int DEF_CLASS_BITS = 1;
  localparam int DEF_DEST_BITS  = 1;
  localparam int DEF_DATA_SIZE  = DEF_MAIN_SIZE + DEF_CLASS_BITS + DEF_DEST_BITS;

  // Default word layout is {class, dest, payload} with class in the MSBs.
  localparam int CLS_MSB = DEF_DATA_SIZE - 1;
  localparam int DST_LSB = DEF_MAIN_SIZE;

  localparam int ARB_STRICT = 0;
  localparam int ARB_RR     = 1;

  function automatic int num_of(input int bits);
    return 1 << bits;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - synchronous FIFO with registered occupancy flags
// Purpose: single-clock FIFO; flags are registered from the next-state count.
// Ports:   clk, reset (sync, active-low), push/push_data, pop, head (current
//          read word), empty/full/almost_full/almost_empty flags, and
//          overflow/underflow pulses for a push to full / pop from empty.
module sync_fifo_flags
  import pcie_switch_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             do_push, do_pop;

  always_comb begin
    // Registered full/empty gate the operations, so a same-edge pop never
    // makes room for a push into a FIFO that is full at that edge.
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(AF_LVL));
    ae_d    = (count_d <= CW'(AE_LVL));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = push && full_q;
  assign underflow    = pop && empty_q;

endmodule

// File: rtl/pcie_class_route_switch.sv
// rtl/pcie_class_route_switch.sv - class FIFOs, arbiter, crossbar and dest FIFOs
// Purpose: sorts input words into per-class FIFOs, moves at most one head per
//          cycle into the per-destination FIFO named by its dest field, and
//          lets software pop each destination into a registered output slice.
// Ports:   clk, reset (sync, active-low); in/in_valid push; pop[d] per dest;
//          out/out_valid registered pop results; class_pause, dest_* flags;
//          Error sticky until reset.
module pcie_class_route_switch
  import pcie_switch_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int MAIN_SIZE  = DEF_MAIN_SIZE,
  parameter int CLASS_BITS = DEF_CLASS_BITS,
  parameter int DEST_BITS  = DEF_DEST_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LVL     = 3,
  parameter int AE_LVL     = 1,
  parameter int ARB_MODE   = ARB_STRICT,
  localparam int NUM_CLASS = num_of(CLASS_BITS),
  localparam int NUM_DEST  = num_of(DEST_BITS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_SIZE-1:0]          in,
  input  logic                          in_valid,
  input  logic [NUM_DEST-1:0]           pop,
  output logic [NUM_DEST*MAIN_SIZE-1:0] out,
  output logic [NUM_DEST-1:0]           out_valid,
  output logic [NUM_CLASS-1:0]          class_pause,
  output logic [NUM_DEST-1:0]           dest_almost_full,
  output logic [NUM_DEST-1:0]           dest_almost_empty,
  output logic [NUM_DEST-1:0]           dest_empty,
  output logic                          Error
);

  localparam int CLS_MSB_I = DATA_SIZE - 1;
  localparam int DST_LSB_I = MAIN_SIZE;

  logic [CLASS_BITS-1:0] in_cls;
  logic [DATA_SIZE-1:0]  cls_head [NUM_CLASS];
  logic [NUM_CLASS-1:0]  cls_push, cls_pop, cls_empty, cls_full, cls_af, cls_ae;
  logic [NUM_CLASS-1:0]  cls_ovf, cls_unf;
  logic [MAIN_SIZE-1:0]  dst_head [NUM_DEST];
  logic [NUM_DEST-1:0]   dst_push, dst_empty, dst_full, dst_af, dst_ae;
  logic [NUM_DEST-1:0]   dst_ovf, dst_unf;

  logic [NUM_CLASS-1:0]  elig;
  logic [CLASS_BITS-1:0] rr_ptr_q, rr_ptr_d, base, idx, win;
  logic                  move;
  logic [DEST_BITS-1:0]  win_dst;
  logic [MAIN_SIZE-1:0]  win_payload;

  logic [NUM_DEST*MAIN_SIZE-1:0] out_q, out_d;
  logic [NUM_DEST-1:0]           out_valid_q, out_valid_d;
  logic                          error_q, error_d;
  logic                          unused_flags;

  assign in_cls = in[CLS_MSB_I -: CLASS_BITS];

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cls
    assign cls_push[c] = in_valid && (in_cls == CLASS_BITS'(c));
    sync_fifo_flags #(
      .WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
    ) u_fifo (
      .clk(clk), .reset(reset), .push(cls_push[c]), .push_data(in),
      .pop(cls_pop[c]), .head(cls_head[c]), .empty(cls_empty[c]),
      .full(cls_full[c]), .almost_full(cls_af[c]), .almost_empty(cls_ae[c]),
      .overflow(cls_ovf[c]), .underflow(cls_unf[c])
    );
  end

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_dst
    sync_fifo_flags #(
      .WIDTH(MAIN_SIZE), .DEPTH(FIFO_DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
    ) u_fifo (
      .clk(clk), .reset(reset), .push(dst_push[d]), .push_data(win_payload),
      .pop(pop[d]), .head(dst_head[d]), .empty(dst_empty[d]),
      .full(dst_full[d]), .almost_full(dst_af[d]), .almost_empty(dst_ae[d]),
      .overflow(dst_ovf[d]), .underflow(dst_unf[d])
    );
  end

  // Arbiter: scan classes starting at base; strict mode always starts at 0.
  // Eligibility is per class, so a head blocked on a full dest never stalls
  // the others.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      elig[c] = !cls_empty[c] && !dst_full[cls_head[c][DST_LSB_I +: DEST_BITS]];
    end
    base = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    move = 1'b0;
    win  = '0;
    idx  = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      idx = base + CLASS_BITS'(i);
      if (!move && elig[idx]) begin
        move = 1'b1;
        win  = idx;
      end
    end
    win_dst     = cls_head[win][DST_LSB_I +: DEST_BITS];
    win_payload = cls_head[win][MAIN_SIZE-1:0];
    rr_ptr_d    = rr_ptr_q;
    if (move && (ARB_MODE == ARB_RR)) rr_ptr_d = win + 1'b1;
    cls_pop  = '0;
    dst_push = '0;
    if (move) begin
      cls_pop[win]      = 1'b1;
      dst_push[win_dst] = 1'b1;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      if (pop[d] && !dst_empty[d]) begin
        out_d[d*MAIN_SIZE +: MAIN_SIZE] = dst_head[d];
        out_valid_d[d]                  = 1'b1;
      end
    end
    // Dest overflow and class underflow cannot occur through the arbiter;
    // folding them in keeps Error honest if that ever changes.
    error_d = error_q | (|cls_ovf) | (|dst_unf) | (|dst_ovf) | (|cls_unf);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      out_q       <= '0;
      out_valid_q <= '0;
      error_q     <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

  assign unused_flags      = ^{cls_full, cls_ae};
  assign out               = out_q;
  assign out_valid         = out_valid_q;
  assign class_pause       = cls_af;
  assign dest_almost_full  = dst_af;
  assign dest_almost_empty = dst_ae;
  assign dest_empty        = dst_empty;
  assign Error             = error_q;

endmodule

// File: tb/tb_pcie_class_route_switch.sv
// tb/tb_pcie_class_route_switch.sv - self-checking bench for pcie_class_route_switch
module tb_pcie_class_route_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: default parameters, strict priority.
  logic [9:0]  in_a;
  logic        in_valid_a;
  logic [1:0]  pop_a;
  logic [15:0] out_a;
  logic [1:0]  out_valid_a, cp_a, daf_a, dae_a, de_a;
  logic        err_a;

  // Instance B: four classes, round robin.
  logic [10:0] in_b;
  logic        in_valid_b;
  logic [1:0]  pop_b;
  logic [15:0] out_b;
  logic [1:0]  out_valid_b, daf_b, dae_b, de_b;
  logic [3:0]  cp_b;
  logic        err_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a [2][$];
  logic [7:0] exp_b [$];

  pcie_class_route_switch dut_a (
    .clk(clk), .reset(rst_n), .in(in_a), .in_valid(in_valid_a), .pop(pop_a),
    .out(out_a), .out_valid(out_valid_a), .class_pause(cp_a),
    .dest_almost_full(daf_a), .dest_almost_empty(dae_a), .dest_empty(de_a),
    .Error(err_a)
  );

  pcie_class_route_switch #(
    .DATA_SIZE(11), .MAIN_SIZE(8), .CLASS_BITS(2), .DEST_BITS(1), .ARB_MODE(1)
  ) dut_b (
    .clk(clk), .reset(rst_n), .in(in_b), .in_valid(in_valid_b), .pop(pop_b),
    .out(out_b), .out_valid(out_valid_b), .class_pause(cp_b),
    .dest_almost_full(daf_b), .dest_almost_empty(dae_b), .dest_empty(de_b),
    .Error(err_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [9:0] w);
    in_a = w; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [10:0] w);
    in_b = w; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_a[0].delete(); exp_a[1].delete(); exp_b.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (out_a !== 16'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0000", out_a); end
    n_checks++; if (out_valid_a !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b want 00", out_valid_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", err_a); end
    n_checks++; if (cp_a !== 2'b00) begin n_fail++; $display("FAIL reset_class_pause: got %b want 00", cp_a); end
    n_checks++; if (daf_a !== 2'b00) begin n_fail++; $display("FAIL reset_almost_full: got %b want 00", daf_a); end
    n_checks++; if (dae_a !== 2'b11) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 11", dae_a); end
    n_checks++; if (de_a !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b want 11", de_a); end
    n_checks++; if ({cp_b, de_b, err_b} !== 7'b0000_11_0) begin n_fail++; $display("FAIL reset_rr_flags: got %b want 0000110", {cp_b, de_b, err_b}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_latency();
    logic [7:0] w;
    push_a(10'h2A5);
    exp_a[0].push_back(8'hA5);
    tick();
    n_checks++; if (de_a[0] !== 1'b0) begin n_fail++; $display("FAIL basic_dest_empty: got %b want 0", de_a[0]); end
    n_checks++; if (out_valid_a !== 2'b00) begin n_fail++; $display("FAIL basic_early_valid: got %b want 00", out_valid_a); end
    pop_a = 2'b01;
    tick();
    pop_a = 2'b00;
    n_checks++; if (out_valid_a !== 2'b01) begin n_fail++; $display("FAIL basic_out_valid: got %b want 01", out_valid_a); end
    if (out_valid_a[0]) begin
      w = exp_a[0].pop_front();
      n_checks++; if (out_a[7:0] !== w) begin n_fail++; $display("FAIL basic_payload: got %h want %h", out_a[7:0], w); end
    end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b want 0", err_a); end
    tick();
    n_checks++; if (out_valid_a !== 2'b00) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 00", out_valid_a); end
    n_checks++; if (out_a[7:0] !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %h want a5", out_a[7:0]); end
  endtask

  task automatic test_strict_priority();
    int guard;
    logic [7:0] w;
    for (int k = 0; k < 4; k++) begin
      push_a(10'h200 | 10'(k + 1));
      exp_a[0].push_back(8'(k + 1));
    end
    tick();
    n_checks++; if (daf_a[0] !== 1'b1) begin n_fail++; $display("FAIL strict_prefill_af: got %b want 1", daf_a[0]); end
    push_a(10'h011); exp_a[0].push_back(8'h11);
    push_a(10'h322); exp_a[1].push_back(8'h22);
    tick();
    n_checks++; if (de_a[1] !== 1'b0) begin n_fail++; $display("FAIL strict_class1_moved: dest_empty[1] got %b want 0", de_a[1]); end
    guard = 0;
    while ((exp_a[0].size() + exp_a[1].size()) != 0 && guard < 60) begin
      pop_a = ~de_a;
      tick();
      pop_a = 2'b00;
      guard++;
      for (int d = 0; d < 2; d++) begin
        if (out_valid_a[d]) begin
          n_checks++;
          if (exp_a[d].size() == 0) begin
            n_fail++; $display("FAIL strict_unexpected d%0d: got %h want none", d, out_a[d*8 +: 8]);
          end else begin
            w = exp_a[d].pop_front();
            if (out_a[d*8 +: 8] !== w) begin n_fail++; $display("FAIL strict_order d%0d: got %h want %h", d, out_a[d*8 +: 8], w); end
          end
        end
      end
    end
    n_checks++; if ((exp_a[0].size() + exp_a[1].size()) != 0) begin n_fail++; $display("FAIL strict_drain: %0d words left want 0", exp_a[0].size() + exp_a[1].size()); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL strict_error: got %b want 0", err_a); end
  endtask

  task automatic test_round_robin();
    int guard;
    logic [7:0] w;
    for (int k = 0; k < 4; k++) begin
      push_b({2'd3, 1'b0, 8'(8'hF0 + k)});
      exp_b.push_back(8'(8'hF0 + k));
    end
    tick();
    n_checks++; if (daf_b[0] !== 1'b1) begin n_fail++; $display("FAIL rr_prefill_af: got %b want 1", daf_b[0]); end
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        push_b({2'(c), 1'b0, 8'(c * 16 + k)});
        exp_b.push_back(8'(c * 16 + k));
      end
    end
    n_checks++; if (cp_b !== 4'b0000) begin n_fail++; $display("FAIL rr_class_pause: got %b want 0000", cp_b); end
    guard = 0;
    while (exp_b.size() != 0 && guard < 60) begin
      pop_b = {1'b0, ~de_b[0]};
      tick();
      pop_b = 2'b00;
      guard++;
      if (out_valid_b[0]) begin
        w = exp_b.pop_front();
        n_checks++; if (out_b[7:0] !== w) begin n_fail++; $display("FAIL rr_order: got %h want %h", out_b[7:0], w); end
      end
    end
    n_checks++; if (exp_b.size() != 0) begin n_fail++; $display("FAIL rr_drain: %0d words left want 0", exp_b.size()); end
    n_checks++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL rr_error: got %b want 0", err_b); end
  endtask

  task automatic test_class_overflow();
    int guard;
    logic [7:0] w;
    for (int k = 0; k < 4; k++) begin
      push_a(10'h240 | 10'(k));
      exp_a[0].push_back(8'(8'h40 + k));
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      push_a(10'h050 | 10'(k));
      if (k < 4) exp_a[0].push_back(8'(8'h50 + k));
      case (k)
        1: begin n_checks++; if (cp_a[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_pause_early: got %b want 0", cp_a[0]); end end
        2: begin n_checks++; if (cp_a[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_pause: got %b want 1", cp_a[0]); end end
        3: begin n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ovf_error_early: got %b want 0", err_a); end end
        4: begin n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b want 1", err_a); end end
        default: ;
      endcase
    end
    guard = 0;
    while (exp_a[0].size() != 0 && guard < 60) begin
      pop_a = {1'b0, ~de_a[0]};
      tick();
      pop_a = 2'b00;
      guard++;
      if (out_valid_a[0]) begin
        w = exp_a[0].pop_front();
        n_checks++; if (out_a[7:0] !== w) begin n_fail++; $display("FAIL ovf_order: got %h want %h", out_a[7:0], w); end
      end
    end
    n_checks++; if (exp_a[0].size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d words left want 0", exp_a[0].size()); end
    n_checks++; if (de_a[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_dropped: dest_empty got %b want 1", de_a[0]); end
    do_reset();
  endtask

  task automatic test_pop_empty();
    n_checks++; if (de_a[1] !== 1'b1) begin n_fail++; $display("FAIL popempty_pre: got %b want 1", de_a[1]); end
    pop_a = 2'b10;
    tick();
    pop_a = 2'b00;
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL popempty_error: got %b want 1", err_a); end
    n_checks++; if (out_valid_a !== 2'b00) begin n_fail++; $display("FAIL popempty_valid: got %b want 00", out_valid_a); end
    tick(); tick(); tick();
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL popempty_sticky: got %b want 1", err_a); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL popempty_clear: got %b want 0", err_a); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_flush();
    for (int k = 0; k < 4; k++) push_a(10'h030 | 10'(k));
    for (int k = 0; k < 4; k++) push_a(10'h330 | 10'(k));
    tick();
    push_a(10'h038); push_a(10'h039);
    push_a(10'h338); push_a(10'h339);
    n_checks++; if (daf_a !== 2'b11) begin n_fail++; $display("FAIL flush_pre_full: got %b want 11", daf_a); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (de_a !== 2'b11) begin n_fail++; $display("FAIL flush_empty: got %b want 11", de_a); end
    n_checks++; if ({dae_a, daf_a, cp_a, out_valid_a} !== 8'b11_00_00_00) begin n_fail++; $display("FAIL flush_flags: got %b want 11000000", {dae_a, daf_a, cp_a, out_valid_a}); end
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (de_a !== 2'b11) begin n_fail++; $display("FAIL flush_nothing_moved: got %b want 11", de_a); end
    pop_a = 2'b01;
    tick();
    pop_a = 2'b00;
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL flush_pop_error: got %b want 1", err_a); end
    n_checks++; if (out_valid_a !== 2'b00) begin n_fail++; $display("FAIL flush_pop_valid: got %b want 00", out_valid_a); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_a = '0; in_valid_a = 1'b0; pop_a = '0;
    in_b = '0; in_valid_b = 1'b0; pop_b = '0;
    test_reset();
    test_basic_latency();
    test_strict_priority();
    test_round_robin();
    test_class_overflow();
    test_pop_empty();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
